// File: rtl/adder_arbiter.sv
// Round-robin front end that time-shares one 16-bit carry-lookahead adder
// among NUM_REQ requesters, with registered operands and a held response.

module adder_lookahead16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;
  logic        cin;

  assign cin   = 1'b0;
  assign g     = a & b;
  assign p     = a ^ b;
  assign gc[0] = cin;

  // Four 4-bit groups; bit carries inside a group are expanded from the group carry-in.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_grp
      localparam int B = 4 * gi;
      assign gg[gi]  = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                     | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign gp[gi]  = &p[B+3:B];
      assign c[B]    = gc[gi];
      assign c[B+1]  = g[B] | (p[B] & gc[gi]);
      assign c[B+2]  = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[gi]);
      assign c[B+3]  = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                     | (p[B+2] & p[B+1] & p[B] & gc[gi]);
    end
  endgenerate

  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

  assign sum  = p ^ c;
  assign cout = gc[4];
endmodule

module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [16*NUM_REQ-1:0] req_operand1,
  input  logic [16*NUM_REQ-1:0] req_operand2,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_result,
  output logic                  rsp_cout,
  output logic [15:0]           ops_done
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [15:0]     op1_q, op1_d;
  logic [15:0]     op2_q, op2_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [15:0]     rsp_result_q, rsp_result_d;
  logic            rsp_cout_q, rsp_cout_d;
  logic [15:0]     ops_done_q, ops_done_d;

  logic [15:0]     op1_arr [NUM_REQ];
  logic [15:0]     op2_arr [NUM_REQ];
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [15:0]     add_sum;
  logic            add_cout;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op1_arr[gi] = req_operand1[16*gi +: 16];
      assign op2_arr[gi] = req_operand2[16*gi +: 16];
    end
  endgenerate

  // First valid requester at or after ptr, wrapping around.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && req_valid[ID_W'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !rst && grant_found) req_ready[grant_idx] = 1'b1;
  end

  adder_lookahead16 u_adder (
    .a    (op1_q),
    .b    (op2_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    int nxt;
    state_d      = state_q;
    ptr_d        = ptr_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_cout_d   = rsp_cout_q;
    ops_done_d   = ops_done_q;
    nxt          = int'(grant_idx) + 1;
    if (nxt >= NUM_REQ) nxt = 0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          op1_d   = op1_arr[grant_idx];
          op2_d   = op2_arr[grant_idx];
          id_d    = grant_idx;
          ptr_d   = ID_W'(nxt);
          state_d = CALC;
        end
      end
      CALC: begin
        rsp_result_d = add_sum;
        rsp_cout_d   = add_cout;
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          ops_done_d  = ops_done_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_cout_q   <= rsp_cout_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_cout   = rsp_cout_q;
  assign ops_done   = ops_done_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: vector table of single transactions plus
// round-robin, backpressure, mid-operation reset and counter-wrap sequences.

module tb_adder_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [16*N-1:0] req_operand1;
  logic [16*N-1:0] req_operand2;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [15:0]     rsp_result;
  logic            rsp_cout;
  logic [15:0]     ops_done;

  adder_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_operand1 (req_operand1),
    .req_operand2 (req_operand2),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_cout     (rsp_cout),
    .ops_done     (ops_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        cout;
  } vec_t;

  vec_t        vecs [8];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [15:0] exp_ops;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b0;
    exp_ops = 16'h0000;
  endtask

  // One isolated transaction: grant, CALC, RESP (accepted at once), back to IDLE.
  task automatic do_op(input string name, input int id, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] res, input logic cout);
    @(negedge clk);
    req_operand1[16*id +: 16] = a;
    req_operand2[16*id +: 16] = b;
    req_valid = N'(1) << id;
    rsp_ready = 1'b1;
    #1 check({name, ".grant"}, 32'(req_ready), 32'd1 << id);
    @(negedge clk);
    #1 check({name, ".calc_ready"}, 32'(req_ready), 32'd0);
    check({name, ".calc_valid"}, 32'(rsp_valid), 32'd0);
    req_valid = '0;
    @(negedge clk);
    #1 check({name, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({name, ".rsp_id"}, 32'(rsp_id), 32'(id));
    check({name, ".rsp_result"}, 32'(rsp_result), 32'(res));
    check({name, ".rsp_cout"}, 32'(rsp_cout), 32'(cout));
    @(negedge clk);
    exp_ops = exp_ops + 16'd1;
    #1 check({name, ".ops_done"}, 32'(ops_done), 32'(exp_ops));
    check({name, ".idle_valid"}, 32'(rsp_valid), 32'd0);
    $display("op %s: id=%0d 0x%04h+0x%04h -> 0x%04h cout=%0d ops_done=%0d",
             name, id, a, b, rsp_result, rsp_cout, ops_done);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          exp_order [6];
    int          ng;
    int          last_cyc;
    int          last_g;
    int          g;
    logic [16:0] s;

    vecs[0] = '{2, 16'h1234, 16'h4321, 16'h5555, 1'b0};
    vecs[1] = '{0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vecs[2] = '{0, 16'h8000, 16'h8000, 16'h0000, 1'b1};
    vecs[3] = '{0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0};
    vecs[4] = '{1, 16'hABCD, 16'h1234, 16'hBE01, 1'b0};
    vecs[5] = '{3, 16'hF0F0, 16'h0F10, 16'h0000, 1'b1};
    vecs[6] = '{3, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0};
    vecs[7] = '{1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
    exp_order = '{0, 1, 2, 3, 0, 1};

    rst          = 1'b1;
    req_valid    = '0;
    req_operand1 = '0;
    req_operand2 = '0;
    rsp_ready    = 1'b0;
    exp_ops      = 16'h0000;

    // Reset state, with every requester asserting valid while rst is high.
    @(negedge clk);
    req_valid = '1;
    @(negedge clk);
    #1 check("reset.req_ready", 32'(req_ready), 32'd0);
    check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset.rsp_id", 32'(rsp_id), 32'd0);
    check("reset.rsp_result", 32'(rsp_result), 32'd0);
    check("reset.rsp_cout", 32'(rsp_cout), 32'd0);
    check("reset.ops_done", 32'(ops_done), 32'd0);
    req_valid = '0;
    rst       = 1'b0;

    for (int i = 0; i < 8; i++)
      do_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].cout);

    // Round-robin with all requesters continuously valid.
    apply_reset();
    for (int i = 0; i < N; i++) begin
      req_operand1[16*i +: 16] = 16'h1111 * 16'(i + 1);
      req_operand2[16*i +: 16] = 16'h0100 + 16'(i);
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    ng = 0;
    last_cyc = -1;
    last_g = -1;
    for (int cyc = 0; cyc < 40 && ng < 6; cyc++) begin
      #1;
      if (rsp_valid && last_g >= 0) begin
        s = {1'b0, 16'h1111 * 16'(last_g + 1)} + {1'b0, 16'h0100 + 16'(last_g)};
        check("rr.rsp_id", 32'(rsp_id), 32'(last_g));
        check("rr.rsp_result", 32'({rsp_cout, rsp_result}), 32'(s));
      end
      if (req_ready != '0) begin
        g = 0;
        for (int k = 0; k < N; k++) if (req_ready[k]) g = k;
        check("rr.onehot", 32'($countones(req_ready)), 32'd1);
        check("rr.order", 32'(g), 32'(exp_order[ng]));
        if (ng > 0) check("rr.gap", 32'(cyc - last_cyc), 32'd3);
        $display("rr grant %0d -> requester %0d at cycle %0d", ng, g, cyc);
        last_cyc = cyc;
        last_g   = g;
        ng++;
      end
      @(negedge clk);
    end
    check("rr.grant_count", 32'(ng), 32'd6);
    req_valid = '0;
    repeat (4) @(negedge clk);

    // Backpressure: response held for 5 cycles while requesters 1 and 3 wait.
    apply_reset();
    req_operand1[16*1 +: 16] = 16'h9000;
    req_operand2[16*1 +: 16] = 16'h7001;
    req_operand1[16*3 +: 16] = 16'h0042;
    req_operand2[16*3 +: 16] = 16'h0058;
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1 check("bp.grant1", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = 4'b1010;
    #1 check("bp.calc_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1 check("bp.hold_valid", 32'(rsp_valid), 32'd1);
      check("bp.hold_id", 32'(rsp_id), 32'd1);
      check("bp.hold_result", 32'(rsp_result), 32'h0001);
      check("bp.hold_cout", 32'(rsp_cout), 32'd1);
      check("bp.hold_ready", 32'(req_ready), 32'd0);
      $display("bp hold cycle %0d: valid=%0d id=%0d result=0x%04h", k, rsp_valid, rsp_id, rsp_result);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1 check("bp.next_grant", 32'(req_ready), 32'b1000);
    check("bp.cleared", 32'(rsp_valid), 32'd0);
    check("bp.ops_done1", 32'(ops_done), 32'd1);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1 check("bp.rsp3_id", 32'(rsp_id), 32'd3);
    check("bp.rsp3_result", 32'({rsp_cout, rsp_result}), 32'h0009A);
    @(negedge clk);
    #1 check("bp.ops_done2", 32'(ops_done), 32'd2);

    // Reset asserted while in CALC.
    apply_reset();
    req_operand1[16*2 +: 16] = 16'h1234;
    req_operand2[16*2 +: 16] = 16'h4321;
    req_operand1[16*3 +: 16] = 16'h0001;
    req_operand2[16*3 +: 16] = 16'h0002;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1 check("rst.grant2", 32'(req_ready), 32'b0100);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 4'b1100;
    #1 check("rst.ready_in_rst", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst.no_rsp", 32'(rsp_valid), 32'd0);
    check("rst.ops_done", 32'(ops_done), 32'd0);
    check("rst.lowest_grant", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = '0;
    #1 check("rst.calc_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #1 check("rst.rsp_id", 32'(rsp_id), 32'd2);
    check("rst.rsp_result", 32'(rsp_result), 32'h5555);
    @(negedge clk);
    #1 check("rst.ops_done1", 32'(ops_done), 32'd1);

    // Counter wrap via a preload of the completion counter.
    @(negedge clk);
    force dut.ops_done_q = 16'hFFFF;
    @(negedge clk);
    release dut.ops_done_q;
    #1 check("wrap.preload", 32'(ops_done), 32'hFFFF);
    exp_ops = 16'hFFFF;
    do_op("wrap", 1, 16'h0003, 16'h0004, 16'h0007, 1'b0);
    check("wrap.zero", 32'(ops_done), 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
